// File: rtl/memarb_if.sv
// Bus bundle between the memory arbiter, its two masters and the memory.
// Handshake: a master raises req with stable wen/addr/wdata and holds it
// (level) until its one-cycle ack; ack marks completion and, for a read,
// the rdata register is already valid in the ack cycle.
interface memarb_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_wen;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait;
  logic          dma_req;
  logic          dma_wen;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;
  logic          mem_cs;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  dma_req, dma_wen, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_wait,
    output dma_rdata, dma_ack,
    output mem_cs, mem_wen, mem_addr, mem_wdata, owner
  );

  // Masters and memory side.
  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output dma_req, dma_wen, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_wait,
    input  dma_rdata, dma_ack,
    input  mem_cs, mem_wen, mem_addr, mem_wdata, owner
  );
endinterface

// File: rtl/memarb.sv
// Two-master arbiter for one single-port synchronous memory.
// CPU wins ties unless it has already taken STARVE consecutive grants
// while the DMA master was waiting. Each access runs IDLE -> ACC (WAIT+1
// cycles) -> ACK (one cycle) -> IDLE.
module memarb #(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int WAIT   = 1,
  parameter int STARVE = 4
) (
  input  logic       clk,
  input  logic       reset,
  memarb_if.slave    bus,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_C   = 4'(WAIT);
  localparam logic [3:0] STARVE_C = 4'(STARVE);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  state_t        state;
  logic [3:0]    cnt;
  logic [3:0]    streak;
  logic          mem_cs_q;
  logic          mem_wen_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;
  logic          cpu_ack_q;
  logic          dma_ack_q;
  logic [1:0]    owner_q;
  logic          grant_dma;

  // DMA wins when it is alone, or when the CPU streak has hit the limit.
  always_comb begin
    grant_dma = bus.dma_req & (~bus.cpu_req | (streak == STARVE_C));
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      streak      <= 4'd0;
      mem_cs_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      owner_q     <= OWN_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          owner_q   <= OWN_NONE;
          if (grant_dma) begin
            state       <= ACC;
            mem_cs_q    <= 1'b1;
            mem_wen_q   <= bus.dma_wen;
            mem_addr_q  <= bus.dma_addr;
            mem_wdata_q <= bus.dma_wdata;
            owner_q     <= OWN_DMA;
            cnt         <= WAIT_C;
            streak      <= 4'd0;
          end else if (bus.cpu_req) begin
            state       <= ACC;
            mem_cs_q    <= 1'b1;
            mem_wen_q   <= bus.cpu_wen;
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
            owner_q     <= OWN_CPU;
            cnt         <= WAIT_C;
            // Streak only grows while DMA is actually being held off.
            if (bus.dma_req) begin
              streak <= (streak == STARVE_C) ? streak : streak + 4'd1;
            end else begin
              streak <= 4'd0;
            end
          end
        end
        ACC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Last wait cycle: memory read data is valid now.
            if (!mem_wen_q) begin
              if (owner_q == OWN_DMA) dma_rdata_q <= bus.mem_rdata;
              else                    cpu_rdata_q <= bus.mem_rdata;
            end
            state     <= ACK;
            mem_cs_q  <= 1'b0;
            mem_wen_q <= 1'b0;
            cpu_ack_q <= (owner_q == OWN_CPU);
            dma_ack_q <= (owner_q == OWN_DMA);
          end
        end
        ACK: begin
          // Requests are ignored here; a held req is re-seen in IDLE.
          state     <= IDLE;
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          owner_q   <= OWN_NONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.owner     = owner_q;
  assign bus.cpu_wait  = bus.cpu_req & ~cpu_ack_q;
  assign fsm_state     = state;

endmodule

// File: tb/tb_memarb.sv
// Directed bench for memarb: three instances cover WAIT=1 (read,
// arbitration, streak restart, async reset), WAIT=0 (DMA write) and
// WAIT=3 (request dropped mid-access).
module tb_memarb;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  memarb_if #(.AW(16), .DW(32)) ia ();
  memarb_if #(.AW(16), .DW(32)) ib ();
  memarb_if #(.AW(16), .DW(32)) ic ();
  logic [1:0] fsm_a, fsm_b, fsm_c;

  memarb #(.AW(16), .DW(32), .WAIT(1), .STARVE(4)) u_a (
    .clk(clk), .reset(reset), .bus(ia), .fsm_state(fsm_a));
  memarb #(.AW(16), .DW(32), .WAIT(0), .STARVE(4)) u_b (
    .clk(clk), .reset(reset), .bus(ib), .fsm_state(fsm_b));
  memarb #(.AW(16), .DW(32), .WAIT(3), .STARVE(4)) u_c (
    .clk(clk), .reset(reset), .bus(ic), .fsm_state(fsm_c));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Move just past the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_mem_cs"},    32'(ia.mem_cs),    32'd0);
    check({tag, "_mem_wen"},   32'(ia.mem_wen),   32'd0);
    check({tag, "_mem_addr"},  32'(ia.mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, ia.mem_wdata,      32'd0);
    check({tag, "_cpu_rdata"}, ia.cpu_rdata,      32'd0);
    check({tag, "_dma_rdata"}, ia.dma_rdata,      32'd0);
    check({tag, "_acks"},      32'({ia.dma_ack, ia.cpu_ack}), 32'd0);
    check({tag, "_owner"},     32'(ia.owner),     32'd0);
    check({tag, "_state"},     32'(fsm_a),        32'd0);
  endtask

  logic [1:0] obs;
  logic [1:0] exp_owner;
  logic       prev;
  int         acks;

  initial begin
    {ia.cpu_req, ia.cpu_wen, ia.dma_req, ia.dma_wen} = '0;
    {ib.cpu_req, ib.cpu_wen, ib.dma_req, ib.dma_wen} = '0;
    {ic.cpu_req, ic.cpu_wen, ic.dma_req, ic.dma_wen} = '0;
    ia.cpu_addr = '0; ia.cpu_wdata = '0; ia.dma_addr = '0; ia.dma_wdata = '0; ia.mem_rdata = '0;
    ib.cpu_addr = '0; ib.cpu_wdata = '0; ib.dma_addr = '0; ib.dma_wdata = '0; ib.mem_rdata = '0;
    ic.cpu_addr = '0; ic.cpu_wdata = '0; ic.dma_addr = '0; ic.dma_wdata = '0; ic.mem_rdata = '0;

    // Reset values.
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check_a_zero("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // CPU read, WAIT=1.
    step();
    ia.cpu_req = 1'b1; ia.cpu_wen = 1'b0; ia.cpu_addr = 16'h1234;
    ia.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("rd_c0_state", 32'(fsm_a), 32'd0);
    check("rd_c0_cs", 32'(ia.mem_cs), 32'd0);
    check("rd_c0_wait", 32'(ia.cpu_wait), 32'd1);
    @(negedge clk);
    check("rd_c1_cs", 32'(ia.mem_cs), 32'd1);
    check("rd_c1_addr", 32'(ia.mem_addr), 32'h1234);
    check("rd_c1_owner", 32'(ia.owner), 32'd1);
    @(negedge clk);
    check("rd_c2_cs", 32'(ia.mem_cs), 32'd1);
    check("rd_c2_ack", 32'(ia.cpu_ack), 32'd0);
    @(negedge clk);
    check("rd_c3_ack", 32'(ia.cpu_ack), 32'd1);
    check("rd_c3_rdata", ia.cpu_rdata, 32'hDEADBEEF);
    check("rd_c3_cs", 32'(ia.mem_cs), 32'd0);
    check("rd_c3_wait", 32'(ia.cpu_wait), 32'd0);
    check("rd_c3_owner", 32'(ia.owner), 32'd1);
    ia.cpu_req = 1'b0;
    @(negedge clk);
    check("rd_c4_state", 32'(fsm_a), 32'd0);
    check("rd_c4_ack", 32'(ia.cpu_ack), 32'd0);
    check("rd_c4_owner", 32'(ia.owner), 32'd0);

    // Both masters requesting continuously, STARVE=4.
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 5 == 4) ? 2'd2 : 2'd1);
    ia.cpu_req = 1'b1; ia.dma_req = 1'b1; ia.dma_addr = 16'h0040;
    acks = 0; prev = 1'b0;
    for (int n = 0; n < 80 && acks < 10; n++) begin
      @(negedge clk);
      obs = {ia.dma_ack, ia.cpu_ack};
      if (obs != 2'd0) begin
        check("arb_prev_ack_low", 32'(prev), 32'd0);
        exp_owner = exp_q.pop_front();
        check("arb_grant_order", 32'(obs), 32'(exp_owner));
        check("arb_owner", 32'(ia.owner), 32'(exp_owner));
        acks++;
        if (acks == 10) begin ia.cpu_req = 1'b0; ia.dma_req = 1'b0; end
      end
      prev = (obs != 2'd0);
    end
    check("arb_ack_count", 32'(acks), 32'd10);
    @(negedge clk);
    check("arb_last_ack_width", 32'({ia.dma_ack, ia.cpu_ack}), 32'd0);
    @(negedge clk);

    // Streak restarts when dma_req drops during a CPU run.
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back((i == 6) ? 2'd2 : 2'd1);
    ia.cpu_req = 1'b1; ia.dma_req = 1'b1;
    acks = 0; prev = 1'b0;
    for (int n = 0; n < 60 && acks < 7; n++) begin
      @(negedge clk);
      obs = {ia.dma_ack, ia.cpu_ack};
      if (obs != 2'd0) begin
        check("stk_prev_ack_low", 32'(prev), 32'd0);
        exp_owner = exp_q.pop_front();
        check("stk_grant_order", 32'(obs), 32'(exp_owner));
        acks++;
        if (acks == 1) ia.dma_req = 1'b0;
        if (acks == 2) ia.dma_req = 1'b1;
        if (acks == 7) begin ia.cpu_req = 1'b0; ia.dma_req = 1'b0; end
      end
      prev = (obs != 2'd0);
    end
    check("stk_ack_count", 32'(acks), 32'd7);

    // DMA read then DMA write, WAIT=0.
    step();
    ib.dma_req = 1'b1; ib.dma_wen = 1'b0; ib.dma_addr = 16'h0020;
    ib.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    check("dr_c1_cs", 32'(ib.mem_cs), 32'd1);
    check("dr_c1_owner", 32'(ib.owner), 32'd2);
    @(negedge clk);
    check("dr_c2_ack", 32'(ib.dma_ack), 32'd1);
    check("dr_c2_rdata", ib.dma_rdata, 32'hCAFEF00D);
    ib.dma_req = 1'b0;
    step();
    ib.dma_req = 1'b1; ib.dma_wen = 1'b1; ib.dma_addr = 16'h0010;
    ib.dma_wdata = 32'h12345678; ib.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("dw_c0_cs", 32'(ib.mem_cs), 32'd0);
    @(negedge clk);
    check("dw_c1_cs", 32'(ib.mem_cs), 32'd1);
    check("dw_c1_wen", 32'(ib.mem_wen), 32'd1);
    check("dw_c1_addr", 32'(ib.mem_addr), 32'h0010);
    check("dw_c1_wdata", ib.mem_wdata, 32'h12345678);
    @(negedge clk);
    check("dw_c2_ack", 32'(ib.dma_ack), 32'd1);
    check("dw_c2_cs", 32'(ib.mem_cs), 32'd0);
    check("dw_c2_wen", 32'(ib.mem_wen), 32'd0);
    check("dw_c2_rdata_kept", ib.dma_rdata, 32'hCAFEF00D);
    ib.dma_req = 1'b0;
    @(negedge clk);
    check("dw_c3_ack", 32'(ib.dma_ack), 32'd0);
    check("dw_c3_state", 32'(fsm_b), 32'd0);

    // cpu_req dropped mid-ACC, WAIT=3.
    step();
    ic.cpu_req = 1'b1; ic.cpu_wen = 1'b0; ic.cpu_addr = 16'h0055;
    ic.mem_rdata = 32'h0BADF00D;
    step();
    @(negedge clk);
    check("drop_c1_cs", 32'(ic.mem_cs), 32'd1);
    step();
    ic.cpu_req = 1'b0;
    @(negedge clk);
    check("drop_c2_wait", 32'(ic.cpu_wait), 32'd0);
    check("drop_c2_cs", 32'(ic.mem_cs), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("drop_c4_ack", 32'(ic.cpu_ack), 32'd0);
    check("drop_c4_cs", 32'(ic.mem_cs), 32'd1);
    @(negedge clk);
    check("drop_c5_ack", 32'(ic.cpu_ack), 32'd1);
    check("drop_c5_rdata", ic.cpu_rdata, 32'h0BADF00D);
    @(negedge clk);
    check("drop_c6_ack", 32'(ic.cpu_ack), 32'd0);
    check("drop_c6_state", 32'(fsm_c), 32'd0);
    @(negedge clk);
    check("drop_c7_state", 32'(fsm_c), 32'd0);

    // Asynchronous reset during ACC of a CPU read, WAIT=1.
    step();
    ia.cpu_req = 1'b1; ia.cpu_wen = 1'b0; ia.cpu_addr = 16'h0ABC;
    ia.cpu_wdata = 32'hA5A5A5A5; ia.mem_rdata = 32'hDEADBEEF;
    step();
    @(negedge clk);
    check("ar_acc_cs", 32'(ia.mem_cs), 32'd1);
    check("ar_acc_wdata", ia.mem_wdata, 32'hA5A5A5A5);
    #1 reset = 1'b0;
    #1;
    check_a_zero("ar");
    @(negedge clk);
    check("ar_held_state", 32'(fsm_a), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ar_regrant_state", 32'(fsm_a), 32'd1);
    check("ar_regrant_cs", 32'(ia.mem_cs), 32'd1);
    check("ar_regrant_addr", 32'(ia.mem_addr), 32'h0ABC);
    @(negedge clk);
    @(negedge clk);
    check("ar_regrant_ack", 32'(ia.cpu_ack), 32'd1);
    check("ar_regrant_rdata", ia.cpu_rdata, 32'hDEADBEEF);
    ia.cpu_req = 1'b0;
    @(negedge clk);
    check("ar_end_state", 32'(fsm_a), 32'd0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
